// File: rtl/branch_pkg.sv
// branch_pkg: shared encodings and default widths for the branch/PC stage
package branch_pkg;
  localparam int PC_W_DEF  = 8;
  localparam int OFF_W_DEF = 8;
  typedef enum logic [1:0] {BR_NONE = 2'b00, BR_Z = 2'b01, BR_NZ = 2'b10, BR_ALWAYS = 2'b11} br_type_e;
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_RUN = 2'b01, S_FLUSH = 2'b10, S_HALT = 2'b11} state_e;
endpackage

// File: rtl/branch_cond.sv
// branch_cond: decides whether the presented branch is taken
//   br_valid_i - decode presents a branch
//   br_type_i  - NONE / BZ / BNZ / BR
//   zero_i     - zero flag of the tested operand
//   take_o     - branch is taken
module branch_cond
  import branch_pkg::*;
(
  input  logic       br_valid_i,
  input  logic [1:0] br_type_i,
  input  logic       zero_i,
  output logic       take_o
);
  always_comb
    take_o = br_valid_i & ((br_type_i == BR_ALWAYS) | ((br_type_i == BR_Z) & zero_i) |
                           ((br_type_i == BR_NZ) & ~zero_i));
endmodule

// File: rtl/branch_pc_unit.sv
// branch_pc_unit: PC register, branch resolution, one-cycle flush bubble and halt
//   clk/rst              - clock, async active-high reset
//   en                   - advance enable, 0 freezes state
//   br_valid/br_type/br_off/zero_in - branch presented by decode and tested flag
//   halt_in              - halt request
//   pc/pc_valid          - fetch address and its validity
//   taken/flush          - one-cycle pulses after a taken branch
//   halted               - block is in HALT
//   taken_cnt            - saturating taken-branch counter (only with BRANCH_PC_UNIT_STATS_EN)
module branch_pc_unit
  import branch_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int OFF_W = OFF_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             br_valid,
  input  logic [1:0]       br_type,
  input  logic [OFF_W-1:0] br_off,
  input  logic             zero_in,
  input  logic             halt_in,
  output logic [PC_W-1:0]  pc,
  output logic             pc_valid,
  output logic             taken,
  output logic             flush,
`ifdef BRANCH_PC_UNIT_STATS_EN
  output logic [15:0]      taken_cnt,
`endif
  output logic             halted
);
  state_e state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic pc_valid_q, pc_valid_d, taken_q, taken_d, flush_q, flush_d, halted_q, halted_d;
  logic take;
  branch_cond u_cond (.br_valid_i(br_valid), .br_type_i(br_type), .zero_i(zero_in), .take_o(take));
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pc_valid_d = pc_valid_q;
    taken_d    = 1'b0;
    flush_d    = 1'b0;
    halted_d   = halted_q;
    if (en) begin
      case (state_q)
        S_IDLE: begin
          state_d    = S_RUN;
          pc_valid_d = 1'b1;
        end
        S_RUN:
          if (halt_in) begin
            state_d    = S_HALT;
            halted_d   = 1'b1;
            pc_valid_d = 1'b0;
          end else if (take) begin
            state_d    = S_FLUSH;
            pc_d       = pc_q + PC_W'($signed(br_off));
            taken_d    = 1'b1;
            flush_d    = 1'b1;
            pc_valid_d = 1'b0;
          end else pc_d = pc_q + PC_W'(1);
        S_FLUSH: begin
          state_d    = S_RUN;
          pc_valid_d = 1'b1;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      pc_valid_q <= 1'b0;
      taken_q    <= 1'b0;
      flush_q    <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
      taken_q    <= taken_d;
      flush_q    <= flush_d;
      halted_q   <= halted_d;
    end
`ifdef BRANCH_PC_UNIT_STATS_EN
  logic [15:0] cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else if (taken_d && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
  assign taken_cnt = cnt_q;
`endif
  assign pc       = pc_q;
  assign pc_valid = pc_valid_q;
  assign taken    = taken_q;
  assign flush    = flush_q;
  assign halted   = halted_q;
endmodule

// File: tb/tb_branch_pc_unit.sv
// tb_branch_pc_unit: table-driven directed check of branch_pc_unit
module tb_branch_pc_unit;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, br_valid = 1'b0, zero_in = 1'b0, halt_in = 1'b0;
  logic [1:0] br_type = 2'b00;
  logic [7:0] br_off = 8'h00;
  logic [7:0] pc;
  logic pc_valid, taken, flush, halted;
`ifdef BRANCH_PC_UNIT_STATS_EN
  logic [15:0] taken_cnt;
`endif
  int n = 0, err = 0;
  always #5 clk = ~clk;
  branch_pc_unit dut (
    .clk(clk), .rst(rst), .en(en), .br_valid(br_valid), .br_type(br_type), .br_off(br_off),
    .zero_in(zero_in), .halt_in(halt_in), .pc(pc), .pc_valid(pc_valid), .taken(taken),
`ifdef BRANCH_PC_UNIT_STATS_EN
    .taken_cnt(taken_cnt),
`endif
    .flush(flush), .halted(halted)
  );
  typedef struct {
    logic e, bv; logic [1:0] t; logic [7:0] o; logic z, h;
    logic [7:0] p; logic pv, tk, fl, hl;
  } vec_t;
  vec_t vecs[$];
  function automatic vec_t mk(input logic e, bv, input logic [1:0] t, input logic [7:0] o,
                              input logic z, h, input logic [7:0] p, input logic pv, tk, fl, hl);
    mk = '{e, bv, t, o, z, h, p, pv, tk, fl, hl};
  endfunction
  task automatic chk(input string nm, input logic [15:0] got, exp);
    n++;
    if (got !== exp) begin
      err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
  task automatic outs(input string nm, input logic [7:0] p, input logic pv, tk, fl, hl);
    chk({nm, ".pc"}, 16'(pc), 16'(p));
    chk({nm, ".pc_valid"}, 16'(pc_valid), 16'(pv));
    chk({nm, ".taken"}, 16'(taken), 16'(tk));
    chk({nm, ".flush"}, 16'(flush), 16'(fl));
    chk({nm, ".halted"}, 16'(halted), 16'(hl));
  endtask
  task automatic step(input vec_t x, input string nm);
    en = x.e; br_valid = x.bv; br_type = x.t; br_off = x.o; zero_in = x.z; halt_in = x.h;
    @(posedge clk);
    #1;
    outs(nm, x.p, x.pv, x.tk, x.fl, x.hl);
  endtask
  initial begin
    //           en    bv    type   off    z     h     pc     pv    tk    fl    hl
    vecs.push_back(mk(1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 8'h03, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 2'b11, 8'h0C, 1'b0, 1'b0, 8'h10, 1'b0, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 2'b01, 8'h05, 1'b1, 1'b0, 8'h15, 1'b0, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 2'b11, 8'h40, 1'b0, 1'b0, 8'h15, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 2'b11, 8'h0B, 1'b0, 1'b0, 8'h20, 1'b0, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 8'h20, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 2'b10, 8'h33, 1'b1, 1'b0, 8'h21, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 2'b01, 8'h33, 1'b0, 1'b0, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 2'b11, 8'h50, 1'b0, 1'b0, 8'h23, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 2'b00, 8'h50, 1'b0, 1'b0, 8'h24, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 8'h24, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 2'b11, 8'hDE, 1'b0, 1'b0, 8'h02, 1'b0, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 2'b11, 8'hFC, 1'b0, 1'b0, 8'hFE, 1'b0, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 2'b11, 8'h10, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 2'b10, 8'h30, 1'b0, 1'b0, 8'h30, 1'b0, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 8'h30, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 2'b11, 8'h05, 1'b0, 1'b1, 8'h30, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, 1'b1, 2'b11, 8'h05, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, 1'b1));
    @(posedge clk);
    @(posedge clk);
    #1;
    outs("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    foreach (vecs[i]) step(vecs[i], $sformatf("vec%0d", i));
`ifdef BRANCH_PC_UNIT_STATS_EN
    chk("cnt_table", taken_cnt, 16'd6);
`endif
    rst = 1'b1;
    #1;
    outs("rst_halt", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step(mk(1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0), "idle_run");
    step(mk(1'b1, 1'b1, 2'b11, 8'h20, 1'b0, 1'b0, 8'h20, 1'b0, 1'b1, 1'b1, 1'b0), "to_flush");
    #2;
    rst = 1'b1;
    #1;
    outs("rst_flush", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef BRANCH_PC_UNIT_STATS_EN
    chk("cnt_reset", taken_cnt, 16'd0);
`endif
    rst = 1'b0;
    step(mk(1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0), "s_run");
    step(mk(1'b1, 1'b1, 2'b01, 8'h04, 1'b1, 1'b0, 8'h04, 1'b0, 1'b1, 1'b1, 1'b0), "s_bz1");
    step(mk(1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0), "s_fl1");
    step(mk(1'b1, 1'b1, 2'b10, 8'h07, 1'b1, 1'b0, 8'h05, 1'b1, 1'b0, 1'b0, 1'b0), "s_bnz0");
    step(mk(1'b1, 1'b1, 2'b11, 8'h03, 1'b0, 1'b0, 8'h08, 1'b0, 1'b1, 1'b1, 1'b0), "s_br");
    step(mk(1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 8'h08, 1'b1, 1'b0, 1'b0, 1'b0), "s_fl2");
    step(mk(1'b1, 1'b1, 2'b01, 8'h07, 1'b0, 1'b0, 8'h09, 1'b1, 1'b0, 1'b0, 1'b0), "s_bz0");
    step(mk(1'b1, 1'b1, 2'b10, 8'h01, 1'b0, 1'b0, 8'h0A, 1'b0, 1'b1, 1'b1, 1'b0), "s_bnz1");
    step(mk(1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 8'h0A, 1'b1, 1'b0, 1'b0, 1'b0), "s_fl3");
`ifdef BRANCH_PC_UNIT_STATS_EN
    chk("cnt_three", taken_cnt, 16'd3);
    force dut.cnt_q = 16'hFFFF;
    #1;
    release dut.cnt_q;
    step(mk(1'b1, 1'b1, 2'b11, 8'h02, 1'b0, 1'b0, 8'h0C, 1'b0, 1'b1, 1'b1, 1'b0), "s_sat");
    chk("cnt_sat", taken_cnt, 16'hFFFF);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n, err);
    $finish;
  end
endmodule
